pipe_register: RTL and testbench

- Parametrised successor to the plain load-enabled register: a STAGES-deep, DATA_BITS-wide pipeline register with valid/ready handshake on both sides.
- Each stage is a 2-entry skid slice, so ready is fully registered and throughput is one word/cycle.
- Used between ChaCha20 quarter-round/column-round stages and the keystream output path to break timing without losing back-pressure.
- Reports occupancy for flow control and debug.

---
 rtl/chacha_pkg.sv | 13 +
 rtl/skid_slice.sv | 68 ++++++
 rtl/pipe_register.sv | 82 ++++++++
 tb/tb_pipe_register.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha20 datapath.
// This file holds the skid slice state encoding and the pipeline depth limit.
package chacha_pkg;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_state_e;

  localparam int MAX_PIPE_STAGES = 8;

endpackage

// File: rtl/skid_slice.sv
// One pipeline stage: a 2-entry skid buffer with a registered ready.
// The output always comes from main. skid catches the word that arrives while the output is stalled.
module skid_slice
  import chacha_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_BITS-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_BITS-1:0] out_data_o
);

  slice_state_e         state;
  logic [DATA_BITS-1:0] main_q;
  logic [DATA_BITS-1:0] skid_q;
  logic                 in_fire;
  logic                 out_fire;

  // ready and valid decode only the state register, so no input reaches them combinationally
  assign in_ready_o  = (state != SLICE_FULL);
  assign out_valid_o = (state != SLICE_EMPTY);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= SLICE_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (clear_i) begin
      state <= SLICE_EMPTY;
    end else begin
      case (state)
        SLICE_EMPTY: begin
          if (in_fire) begin
            state  <= SLICE_ONE;
            main_q <= in_data_i;
          end
        end
        SLICE_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data_i;
          end else if (in_fire) begin
            state  <= SLICE_FULL;
            skid_q <= in_data_i;
          end else if (out_fire) begin
            state <= SLICE_EMPTY;
          end
        end
        SLICE_FULL: begin
          if (out_fire) begin
            state  <= SLICE_ONE;
            main_q <= skid_q;
          end
        end
        default: state <= SLICE_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_register.sv
// STAGES-deep valid/ready pipeline register built from cascaded skid slices, with an occupancy count.
// Define PIPE_REG_CLEAR_EN to add the clear_i synchronous flush input.
module pipe_register
  import chacha_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int STAGES    = 1,
  parameter int OCC_BITS  = $clog2(2*STAGES+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef PIPE_REG_CLEAR_EN
  input  logic                 clear_i,
`endif
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_BITS-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_BITS-1:0] out_data_o,
  output logic [OCC_BITS-1:0]  occupancy_o
);

  if (STAGES < 1 || STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
    $error("pipe_register: STAGES out of range");
  end

  logic [STAGES:0]      valid;
  logic [STAGES:0]      ready;
  logic [DATA_BITS-1:0] data [STAGES+1];
  logic                 clear;
  logic                 in_fire;
  logic                 out_fire;
  logic [OCC_BITS-1:0]  occ_q;

`ifdef PIPE_REG_CLEAR_EN
  assign clear = clear_i;
`else
  assign clear = 1'b0;
`endif

  assign valid[0]      = in_valid_i;
  assign data[0]       = in_data_i;
  assign ready[STAGES] = out_ready_i;
  assign in_ready_o    = ready[0];
  assign out_valid_o   = valid[STAGES];
  assign out_data_o    = data[STAGES];
  assign occupancy_o   = occ_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    skid_slice #(
      .DATA_BITS(DATA_BITS)
    ) u_slice (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear),
      .in_valid_i (valid[k]),
      .in_ready_o (ready[k]),
      .in_data_i  (data[k]),
      .out_valid_o(valid[k+1]),
      .out_ready_i(ready[k+1]),
      .out_data_o (data[k+1])
    );
  end

  assign in_fire  = in_valid_i & ready[0];
  assign out_fire = valid[STAGES] & out_ready_i;

  // Words held across the whole chain. This count moves only at the two ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else if (in_fire && !out_fire) begin
      occ_q <= occ_q + OCC_BITS'(1);
    end else if (out_fire && !in_fire) begin
      occ_q <= occ_q - OCC_BITS'(1);
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Randomized self-checking bench for pipe_register against a queue-based FIFO model.
// Define PIPE_REG_CLEAR_EN to also exercise the clear_i flush.
module tb_pipe_register;

  localparam int DW  = 32;
  localparam int ST  = 3;
  localparam int CAP = 2*ST;
  localparam int OCC = $clog2(2*ST+1);

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [OCC-1:0] occ;
`ifdef PIPE_REG_CLEAR_EN
  logic           clear;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  q [$];
  logic           stall_pending = 1'b0;
  logic [DW-1:0]  stall_data = '0;
  logic           s_valid, s_ready;
  logic [DW-1:0]  s_data;
  logic [OCC-1:0] s_occ;

  pipe_register #(
    .DATA_BITS(DW),
    .STAGES   (ST)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
`ifdef PIPE_REG_CLEAR_EN
    .clear_i    (clear),
`endif
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .occupancy_o(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each call covers one cycle. At the falling edge it checks the outputs against the model,
  // then drives the inputs and moves the model forward to the next rising edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic clr);
    logic in_f, out_f;
    @(negedge clk);
    s_valid = out_valid;
    s_ready = in_ready;
    s_data  = out_data;
    s_occ   = occ;
    checkOutput("occupancy", 64'(occ), 64'(q.size()));
    if (q.size() == 0) checkOutput("empty_valid", 64'(out_valid), 64'd0);
    if (out_valid && q.size() > 0) checkOutput("fifo_order", 64'(out_data), 64'(q[0]));
    if (q.size() == CAP) checkOutput("full_ready", 64'(in_ready), 64'd0);
    if (stall_pending) begin
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_data", 64'(out_data), 64'(stall_data));
    end
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
`ifdef PIPE_REG_CLEAR_EN
    clear = clr;
`endif
    if (clr) begin
      q.delete();
      stall_pending = 1'b0;
    end else begin
      in_f  = iv & in_ready;
      out_f = out_valid & ordy;
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(d);
      stall_pending = out_valid & ~ordy;
      stall_data    = out_data;
    end
  endtask

  task automatic drainAll(input string tag);
    for (int i = 0; i < 60 && q.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput(tag, 64'(q.size()), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int first_out, valid_run, seq;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_REG_CLEAR_EN
    clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_occ", 64'(occ), 64'd0);
    rst_n = 1'b1;
    #1 checkOutput("rst_ready", 64'(in_ready), 64'd1);

    // The first word is offered at the first rising edge and is counted as edge one.
    // The word then takes ST edges to reach the output.
    first_out = -1;
    valid_run = 0;
    seq       = 1;
    for (int i = 0; i < 30; i++) begin
      if (i < 16) applyStimulus(1'b1, DW'(i + 1), 1'b1, 1'b0);
      else        applyStimulus(1'b0, '0, 1'b1, 1'b0);
      if (i < 16) checkOutput("tput_ready", 64'(s_ready), 64'd1);
      if (s_valid) begin
        if (first_out < 0) first_out = i;
        checkOutput("tput_data", 64'(s_data), 64'(seq));
        seq++;
        valid_run++;
      end
    end
    checkOutput("latency", 64'(first_out), 64'(ST));
    checkOutput("tput_count", 64'(valid_run), 64'd16);
    checkOutput("tput_contiguous", 64'(seq - 1), 64'd16);

    // Block the output and keep pushing until the pipe holds its full capacity.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'hA000_0000 + DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAFFF_FFFF, 1'b0, 1'b0);
    checkOutput("fill_occ", 64'(s_occ), 64'(CAP));
    checkOutput("fill_ready", 64'(s_ready), 64'd0);
    checkOutput("fill_valid", 64'(s_valid), 64'd1);
    checkOutput("fill_head", 64'(s_data), 64'h0000_0000_A000_0000);

    // Drain while new words keep arriving, then stop the input and empty the pipe.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 32'hB000_0000 + DW'(i), 1'b1, 1'b0);
    drainAll("drain_empty");
    checkOutput("drain_occ", 64'(s_occ), 64'd0);

    // Assert reset in the middle of a cycle while three words are held.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC000_0000 + DW'(i), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_occ", 64'(occ), 64'd0);
    checkOutput("midrst_data", 64'(out_data), 64'd0);
    q.delete();
    stall_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("midrst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), (i % 500 < 250) ? ($urandom_range(0, 3) == 0)
                                                                             : ($urandom_range(0, 3) != 0), 1'b0);
    end
    drainAll("random_drain");

`ifdef PIPE_REG_CLEAR_EN
    // Clear the pipe while it holds five words and a sixth word is offered in the same cycle.
    for (int i = 0; i < 20 && q.size() < 5; i++) applyStimulus(1'b1, 32'hD000_0000 + DW'(i), 1'b0, 1'b0);
    checkOutput("clr_prefill", 64'(q.size()), 64'd5);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("clr_occ", 64'(s_occ), 64'd0);
    checkOutput("clr_valid", 64'(s_valid), 64'd0);
    checkOutput("clr_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hE000_0000 + DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      if (s_valid && s_data == 32'hDEAD_BEEF) checkOutput("clr_dropped", 64'(s_data), 64'd0);
    end
    checkOutput("clr_drain", 64'(q.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
